cskipa_pipe: RTL

- Parametrised, pipelined carry-skip adder/subtractor; next generation of the fixed-width carry-skip adders in the adder library.
- WIDTH, skip-block size and pipeline depth are parameters; a partial top block is handled automatically.
- Adds carry-in, a subtract mode, a signed-overflow flag and a valid/ready stream interface with backpressure.
- Sits between operand producers and result consumers in the batch adder test harness.

---
 rtl/cskipa_pipe.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cskipa_pipe.sv
// rtl/cskipa_pipe.sv - pipelined carry-skip adder/subtractor with valid/ready stream handshake
module cskipa_pipe #(
    parameter int WIDTH  = 41,
    parameter int BLOCK  = 4,
    parameter int STAGES = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int NBLK = (WIDTH + BLOCK - 1) / BLOCK;
    localparam int IW   = $clog2(WIDTH);
    // Operand registers are only needed between stages; keep at least one so the array is legal
    localparam int OPN  = (STAGES > 1) ? STAGES - 1 : 1;

    generate
        if (WIDTH < 2 || BLOCK < 1 || BLOCK > WIDTH || STAGES < 1 || STAGES > NBLK) begin : g_bad_param
            $error("cskipa_pipe: WIDTH/BLOCK/STAGES out of range");
        end
    endgenerate

    // Per-stage state: valid, inter-stage carry, sum bits completed so far
    logic [STAGES-1:0]            v_q;
    logic [STAGES-1:0]            c_q;
    logic [STAGES-1:0][WIDTH-1:0] s_q;
    // Operands still needed by later stages (full vectors, upper blocks not yet consumed)
    logic [OPN-1:0][WIDTH-1:0]    a_q;
    logic [OPN-1:0][WIDTH-1:0]    b_q;
    // Overflow is resolved in the last stage, which always owns the top block
    logic                         ovf_q;

    // Stage inputs and combinational stage results
    logic [STAGES-1:0]            v_in;
    logic [STAGES-1:0]            c_in;
    logic [STAGES-1:0][WIDTH-1:0] s_in;
    logic [STAGES-1:0][WIDTH-1:0] a_in;
    logic [STAGES-1:0][WIDTH-1:0] b_in;
    logic [STAGES-1:0]            c_nxt;
    logic [STAGES-1:0][WIDTH-1:0] s_nxt;
    logic                         ovf_nxt;

    logic [STAGES-1:0]            ld;
    logic                         ld_free;

    // Bubble-collapsing load enables: a stage loads if it or any stage downstream has room
    always_comb begin
        ld_free = i_ready;
        ld      = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ld_free = ld_free | ~v_q[k];
            ld[k]   = ld_free;
        end
    end

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            localparam int LO = (k * NBLK) / STAGES;
            localparam int HI = ((k + 1) * NBLK) / STAGES;

            logic [WIDTH-1:0] sum_w;
            logic             carry_w;
            logic             rc;
            logic             pall;
            logic             p;
            logic [IW-1:0]    idx;

            if (k == 0) begin : g_src_in
                // Subtraction folds into the adder as A + ~B + ~borrow
                assign v_in[0] = i_valid;
                assign a_in[0] = i_add_term1;
                assign b_in[0] = i_add_term2 ^ {WIDTH{i_sub}};
                assign c_in[0] = i_cin ^ i_sub;
                assign s_in[0] = '0;
            end else begin : g_src_prev
                assign v_in[k] = v_q[k-1];
                assign a_in[k] = a_q[k-1];
                assign b_in[k] = b_q[k-1];
                assign c_in[k] = c_q[k-1];
                assign s_in[k] = s_q[k-1];
            end

            // Evaluate this stage's skip blocks: ripple inside a block, bypass it when fully propagating
            always_comb begin
                sum_w   = s_in[k];
                carry_w = c_in[k];
                rc      = 1'b0;
                pall    = 1'b1;
                p       = 1'b0;
                idx     = '0;
                for (int j = LO; j < HI; j++) begin
                    rc   = carry_w;
                    pall = 1'b1;
                    for (int i = j * BLOCK; (i < j * BLOCK + BLOCK) && (i < WIDTH); i++) begin
                        idx        = IW'(i);
                        p          = a_in[k][idx] ^ b_in[k][idx];
                        sum_w[idx] = p ^ rc;
                        rc         = (a_in[k][idx] & b_in[k][idx]) | (p & rc);
                        pall       = pall & p;
                    end
                    carry_w = pall ? carry_w : rc;
                end
            end

            assign s_nxt[k] = sum_w;
            assign c_nxt[k] = carry_w;
        end
    endgenerate

    assign ovf_nxt = (a_in[STAGES-1][WIDTH-1] == b_in[STAGES-1][WIDTH-1])
                   && (s_nxt[STAGES-1][WIDTH-1] != a_in[STAGES-1][WIDTH-1]);

    // Pipeline registers; data only moves on a valid load so held outputs stay stable
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v_q   <= '0;
            c_q   <= '0;
            s_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (ld[s]) begin
                    v_q[s] <= v_in[s];
                    if (v_in[s]) begin
                        c_q[s] <= c_nxt[s];
                        s_q[s] <= s_nxt[s];
                    end
                end
            end
            for (int s = 0; s < STAGES - 1; s++) begin
                if (ld[s] && v_in[s]) begin
                    a_q[s] <= a_in[s];
                    b_q[s] <= b_in[s];
                end
            end
            if (ld[STAGES-1] && v_in[STAGES-1]) begin
                ovf_q <= ovf_nxt;
            end
        end
    end

    assign o_ready = ld[0];
    assign o_valid = v_q[STAGES-1];
    assign o_sum   = s_q[STAGES-1];
    assign o_cout  = c_q[STAGES-1];
    assign o_ovf   = ovf_q;

endmodule
